uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 111 +++++++++++
 tb/tb_uart_tx_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a uart_send transmitter.
// It pops one byte per transmit cycle and holds the byte steady until the UART takes it.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic [7:0]            DATA,
  output logic                  DATA_READY,
  input  logic                  TX_IDLE
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;

  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count_q;
  logic [DEPTH_LOG2:0]     count_nxt;
  logic                    full_q;
  logic                    empty_q;
  logic                    ovf_q;
  logic [7:0]              data_q;
  logic                    ready_q;
  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic                    wr_acc;
  logic                    pop;

  // FULL is the registered flag, so a write that races a pop on a full FIFO is still dropped
  assign wr_acc = WR_EN & ~full_q;
  assign pop    = (state == S_WAIT) & ~empty_q & TX_IDLE;

  always_comb begin
    count_nxt = count_q;
    unique case (1'b1)
      (wr_acc & ~pop): count_nxt = count_q + 1'b1;
      (~wr_acc & pop): count_nxt = count_q - 1'b1;
      default:         count_nxt = count_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_WAIT:    if (pop) state_nxt = S_PRESENT;
      S_PRESENT: if (!TX_IDLE) state_nxt = S_BUSY;
      S_BUSY:    if (TX_IDLE) state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_CNT);
      empty_q <= (count_nxt == '0);
      if (WR_EN && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_WAIT;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        data_q  <= mem[rd_ptr];
        ready_q <= 1'b1;
      end else if (state == S_PRESENT && !TX_IDLE) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign FULL       = full_q;
  assign EMPTY      = empty_q;
  assign COUNT      = count_q;
  assign OVERFLOW   = ovf_q;
  assign DATA       = data_q;
  assign DATA_READY = ready_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] data;
  logic       data_ready;
  logic       tx_idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .CLK(clk),
    .RST(rst),
    .WR_DATA(wr_data),
    .WR_EN(wr_en),
    .FULL(full),
    .EMPTY(empty),
    .COUNT(count),
    .OVERFLOW(overflow),
    .DATA(data),
    .DATA_READY(data_ready),
    .TX_IDLE(tx_idle)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!data_ready && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // fast consumer: takes the byte, goes busy one cycle, returns idle
  task automatic drain(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      wait_ready();
      chk("drain_ready", data_ready, 1'b1);
      chk("drain_data", data, base + 8'(k));
      tx_idle = 1'b0;
      tick();
      tx_idle = 1'b1;
      tick();
    end
  endtask

  logic [7:0] burst [3];
  int idx_w;
  int idx_r;

  initial begin
    burst[0] = 8'hAA;
    burst[1] = 8'h4C;
    burst[2] = 8'h01;
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tx_idle = 1'b1;
    tick();
    tick();
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", data_ready, 1'b0);
    rst   = 1'b0;
    wr_en = 1'b0;
    tick();
    chk("rst_wr_ignored", count, 5'd0);

    // single byte latency
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("single_cnt1", count, 5'd1);
    chk("single_notyet", data_ready, 1'b0);
    tick();
    chk("single_ready", data_ready, 1'b1);
    chk("single_data", data, 8'hAA);
    chk("single_empty", empty, 1'b1);
    tx_idle = 1'b0;
    tick();
    chk("single_drop", data_ready, 1'b0);
    chk("single_hold", data, 8'hAA);
    tx_idle = 1'b1;
    tick();
    tick();
    chk("single_idle", data_ready, 1'b0);

    // burst with a slow uart model
    tx_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = burst[i];
      tick();
    end
    wr_en = 1'b0;
    chk("burst_cnt3", count, 5'd3);
    tx_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      chk("burst_ready", data_ready, 1'b1);
      chk("burst_data", data, burst[i]);
      chk("burst_cnt", count, 5'(2 - i));
      tx_idle = 1'b0;
      repeat (260) tick();
      chk("burst_busy", data_ready, 1'b0);
      tx_idle = 1'b1;
    end
    repeat (4) tick();
    chk("burst_cnt0", count, 5'd0);
    chk("burst_empty", empty, 1'b1);
    chk("burst_noextra", data_ready, 1'b0);

    // fill and overflow
    do_reset();
    tx_idle = 1'b0;
    fill(16, 8'h10);
    chk("fill_full", full, 1'b1);
    chk("fill_cnt", count, 5'd16);
    chk("fill_noovf", overflow, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_cnt", count, 5'd16);
    tx_idle = 1'b1;
    drain(16, 8'h10);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_drained", empty, 1'b1);

    // wrap: 40 bytes through a 16-deep FIFO
    do_reset();
    idx_w = 0;
    idx_r = 0;
    for (int cyc = 0; cyc < 2000 && idx_r < 40; cyc++) begin
      wr_en   = (idx_w < 40) && !full;
      wr_data = 8'(idx_w);
      if (wr_en) idx_w++;
      if (data_ready && tx_idle) begin
        chk("wrap_data", data, 8'(idx_r));
        idx_r++;
        tx_idle = 1'b0;
      end else begin
        tx_idle = 1'b1;
      end
      tick();
    end
    wr_en   = 1'b0;
    tx_idle = 1'b1;
    chk("wrap_all", idx_r, 40);
    chk("wrap_noovf", overflow, 1'b0);

    // full + pop + write on the same edge
    do_reset();
    tx_idle = 1'b0;
    fill(16, 8'h20);
    chk("race_full", full, 1'b1);
    tx_idle = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("race_cnt", count, 5'd15);
    chk("race_ovf", overflow, 1'b1);
    chk("race_data", data, 8'h20);
    chk("race_nfull", full, 1'b0);
    tx_idle = 1'b0;
    tick();
    tx_idle = 1'b1;
    tick();
    drain(15, 8'h21);

    // reset while presenting with five queued
    do_reset();
    tx_idle = 1'b0;
    fill(6, 8'h60);
    tx_idle = 1'b1;
    tick();
    chk("pres_cnt", count, 5'd5);
    chk("pres_ready", data_ready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", data_ready, 1'b0);
    chk("mid_rst_cnt", count, 5'd0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_data", data, 8'h00);
    tick();
    chk("mid_rst_stay", data_ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
